// File: rtl/asteroid_field.sv
// asteroid_field: falling-asteroid playfield with a PLAY/HIT game state machine.
//
// Up to NUM_AST asteroid channels spawn at the top of the screen at pseudo-random x
// positions and fall once per video frame. A channel that leaves the bottom edge scores
// a point. The pixel under (x, y) is rendered to apixel one clk later. A rocket pixel
// coinciding with apixel ends the game (HIT) until restart.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset, also samples seed into the LFSR
//   frame_tick   one-clk pulse per video frame
//   x, y         current pixel coordinate
//   seed         LFSR seed (0 is replaced by 10'h001)
//   rpixel       rocket pixel, aligned with apixel
//   restart      one-clk pulse, leaves HIT and starts a new game
//   apixel       asteroid covers the pixel presented on the previous clk
//   hit          high while in HIT
//   score        asteroids that left the bottom of the screen (saturating)
//   active_mask  bit i high while channel i is falling
//
// Build option: define ASTEROID_FIELD_SPEEDUP_EN to raise fall speed by one pixel/frame
// every 8 points (capped at MAX_SPEED); otherwise speed is fixed at 1.
module asteroid_field #(
  parameter int unsigned NUM_AST   = 4,
  parameter int unsigned AST_W     = 30,
  parameter int unsigned AST_H     = 20,
  parameter int unsigned X_MAX     = 640,
  parameter int unsigned Y_MAX     = 480,
  parameter int unsigned SPAWN_GAP = 32,
  parameter int unsigned MAX_SPEED = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [9:0]         seed,
  input  logic               rpixel,
  input  logic               restart,
  output logic               apixel,
  output logic               hit,
  output logic [15:0]        score,
  output logic [NUM_AST-1:0] active_mask
);

  localparam int unsigned XRange = X_MAX - AST_W + 1;
  localparam int unsigned CntW   = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  typedef enum logic {StPlay, StHit} state_e;

  state_e              state_q, state_d;
  logic [9:0]          lfsr_q;
  logic [NUM_AST-1:0]  active_q, active_d;
  logic [9:0]          xpos_q [NUM_AST];
  logic [9:0]          xpos_d [NUM_AST];
  logic [9:0]          ypos_q [NUM_AST];
  logic [9:0]          ypos_d [NUM_AST];
  logic [10:0]         ypos_next [NUM_AST];
  logic [15:0]         score_q, score_d;
  logic [CntW-1:0]     spawn_cnt_q, spawn_cnt_d;
  logic                apixel_q, apixel_d;

  logic [3:0]          speed;
  logic [9:0]          spawn_x;
  logic [10:0]         spawn_x_wide;
  logic [NUM_AST-1:0]  spawn_sel;
  logic                any_free;
  logic                play_tick;
  logic                clear_all;
  logic                do_spawn;
  logic [3:0]          exit_cnt;
  logic [16:0]         score_sum;

  // ---------------------------------------------------------------------------------------
  // Game FSM
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StPlay;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPlay: if (rpixel && apixel_q) state_d = StHit;
      // restart wins over a simultaneous collision
      StHit:  if (restart) state_d = StPlay;
      default: state_d = StPlay;
    endcase
  end

  always_comb begin
    hit = (state_q == StHit);
  end

  assign play_tick = frame_tick && (state_q == StPlay);
  assign clear_all = restart && (state_q == StHit);

  // ---------------------------------------------------------------------------------------
  // LFSR: the update is invertible, so a non-zero state never reaches zero.
  // The seed is an asynchronous load while reset is held.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= (seed == 10'd0) ? 10'h001 : seed;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[9], lfsr_q[9:1]};
    end
  end

  assign spawn_x_wide = {1'b0, lfsr_q} % 11'(XRange);
  assign spawn_x      = spawn_x_wide[9:0];

  // ---------------------------------------------------------------------------------------
  // Fall speed
  // ---------------------------------------------------------------------------------------
`ifdef ASTEROID_FIELD_SPEEDUP_EN
  logic [13:0] speed_raw;
  assign speed_raw = 14'd1 + {1'b0, score_q[15:3]};
  assign speed     = (speed_raw > 14'(MAX_SPEED)) ? 4'(MAX_SPEED) : speed_raw[3:0];
`else
  assign speed = 4'd1;
`endif

  // ---------------------------------------------------------------------------------------
  // Channel update
  // ---------------------------------------------------------------------------------------
  // Lowest-index free channel is the spawn target.
  always_comb begin
    spawn_sel = '0;
    any_free  = 1'b0;
    for (int i = 0; i < NUM_AST; i++) begin
      if (!active_q[i] && !any_free) begin
        spawn_sel[i] = 1'b1;
        any_free     = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_AST; i++) begin
      ypos_next[i] = {1'b0, ypos_q[i]} + 11'(speed);
    end
  end

  assign do_spawn = play_tick && (spawn_cnt_q == '0) && any_free;

  always_comb begin
    active_d    = active_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    score_d     = score_q;
    spawn_cnt_d = spawn_cnt_q;
    exit_cnt    = 4'd0;
    score_sum   = 17'd0;
    if (clear_all) begin
      active_d    = '0;
      score_d     = '0;
      spawn_cnt_d = '0;
      for (int i = 0; i < NUM_AST; i++) begin
        xpos_d[i] = '0;
        ypos_d[i] = '0;
      end
    end else if (play_tick) begin
      if (do_spawn) begin
        spawn_cnt_d = CntW'(SPAWN_GAP - 1);
      end else if (spawn_cnt_q != '0) begin
        spawn_cnt_d = spawn_cnt_q - 1'b1;
      end
      for (int i = 0; i < NUM_AST; i++) begin
        if (do_spawn && spawn_sel[i]) begin
          active_d[i] = 1'b1;
          xpos_d[i]   = spawn_x;
          ypos_d[i]   = '0;
        end else if (active_q[i]) begin
          if (ypos_next[i] >= 11'(Y_MAX)) begin
            active_d[i] = 1'b0;
            exit_cnt    = exit_cnt + 4'd1;
          end else begin
            ypos_d[i] = ypos_next[i][9:0];
          end
        end
      end
      score_sum = {1'b0, score_q} + {13'd0, exit_cnt};
      score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Pixel render: 11-bit compares so boxes near the right/bottom edge do not wrap.
  // ---------------------------------------------------------------------------------------
  always_comb begin
    apixel_d = 1'b0;
    for (int i = 0; i < NUM_AST; i++) begin
      if (active_q[i] &&
          ({1'b0, x} >= {1'b0, xpos_q[i]}) && ({1'b0, x} < ({1'b0, xpos_q[i]} + 11'(AST_W))) &&
          ({1'b0, y} >= {1'b0, ypos_q[i]}) && ({1'b0, y} < ({1'b0, ypos_q[i]} + 11'(AST_H)))) begin
        apixel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= '0;
      score_q     <= '0;
      spawn_cnt_q <= '0;
      apixel_q    <= 1'b0;
      for (int i = 0; i < NUM_AST; i++) begin
        xpos_q[i] <= '0;
        ypos_q[i] <= '0;
      end
    end else begin
      active_q    <= active_d;
      score_q     <= score_d;
      spawn_cnt_q <= spawn_cnt_d;
      apixel_q    <= apixel_d;
      for (int i = 0; i < NUM_AST; i++) begin
        xpos_q[i] <= xpos_d[i];
        ypos_q[i] <= ypos_d[i];
      end
    end
  end

  assign apixel      = apixel_q;
  assign score       = score_q;
  assign active_mask = active_q;

endmodule

// File: tb/tb_asteroid_field.sv
// Self-checking bench for asteroid_field: randomized frame ticks, pixel probes biased
// onto live asteroids, occasional rocket hits and restarts, checked by a scoreboard
// against a frame-level reference model of the game.
module tb_asteroid_field;

  localparam int NA  = 4;
  localparam int AW  = 30;
  localparam int AH  = 20;
  localparam int XM  = 640;
  localparam int YM  = 480;
  localparam int GAP = 32;
  localparam int MS  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [9:0]    seed;
  logic          rpixel;
  logic          restart;
  logic          apixel;
  logic          hit;
  logic [15:0]   score;
  logic [NA-1:0] active_mask;

  always #5 clk = ~clk;

  asteroid_field dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .x           (x),
    .y           (y),
    .seed        (seed),
    .rpixel      (rpixel),
    .restart     (restart),
    .apixel      (apixel),
    .hit         (hit),
    .score       (score),
    .active_mask (active_mask)
  );

  typedef struct {
    bit apix;
    bit hit;
    int score;
    int mask;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  bit m_act[NA];
  int m_x[NA];
  int m_y[NA];
  int m_score;
  int m_cnt;
  int m_lfsr;
  bit m_hit;
  bit m_apix;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NA-1:0] m_mask();
    logic [NA-1:0] m;
    for (int i = 0; i < NA; i++) m[i] = m_act[i];
    return m;
  endfunction

  task automatic model_reset(int s);
    for (int i = 0; i < NA; i++) begin
      m_act[i] = 0;
      m_x[i]   = 0;
      m_y[i]   = 0;
    end
    m_score = 0;
    m_cnt   = 0;
    m_hit   = 0;
    m_apix  = 0;
    m_lfsr  = (s == 0) ? 1 : s;
  endtask

  // One clk of game behaviour, given the inputs present at that edge.
  task automatic model_step(bit fr, int px, int py, bit rp, bit rs);
    bit new_apix = 0;
    int spd, s, exits;
    for (int i = 0; i < NA; i++)
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + AW && py >= m_y[i] && py < m_y[i] + AH)
        new_apix = 1;
    if (m_hit) begin
      if (rs) begin
        for (int i = 0; i < NA; i++) m_act[i] = 0;
        m_score = 0;
        m_cnt   = 0;
        m_hit   = 0;
      end
    end else begin
      if (rp && m_apix) m_hit = 1;
      if (fr) begin
`ifdef ASTEROID_FIELD_SPEEDUP_EN
        spd = 1 + m_score / 8;
        if (spd > MS) spd = MS;
`else
        spd = 1;
`endif
        s = -1;
        if (m_cnt == 0) begin
          for (int i = NA - 1; i >= 0; i--) if (!m_act[i]) s = i;
        end
        if (s >= 0) begin
          m_cnt = GAP - 1;
        end else if (m_cnt > 0) begin
          m_cnt--;
        end
        exits = 0;
        for (int i = 0; i < NA; i++) begin
          if (i != s && m_act[i]) begin
            if (m_y[i] + spd >= YM) begin
              m_act[i] = 0;
              exits++;
            end else begin
              m_y[i] += spd;
            end
          end
        end
        if (s >= 0) begin
          m_act[s] = 1;
          m_x[s]   = m_lfsr % (XM - AW + 1);
          m_y[s]   = 0;
        end
        m_score = (m_score + exits > 65535) ? 65535 : m_score + exits;
      end
    end
    m_apix = new_apix;
    m_lfsr = (((m_lfsr ^ (m_lfsr >> 9)) & 1) << 9) | (m_lfsr >> 1);
  endtask

  // Called at a negedge; leaves at the next negedge.
  task automatic drive(bit fr, bit rp, bit rs, int px, int py);
    exp_t e;
    frame_tick = fr;
    rpixel     = rp;
    restart    = rs;
    x          = 10'(px);
    y          = 10'(py);
    model_step(fr, px, py, rp, rs);
    e.apix  = m_apix;
    e.hit   = m_hit;
    e.score = m_score;
    e.mask  = int'(m_mask());
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic random_cycle();
    int px, py, k;
    bit fr, rp, rs;
    fr = ($urandom % 2) == 0;
    px = int'($urandom % 1024);
    py = int'($urandom % 1024);
    if ($urandom % 4 != 0) begin
      k = int'($urandom % NA);
      for (int t = 0; t < NA && !m_act[k]; t++) k = (k + 1) % NA;
      if (m_act[k]) begin
        px = m_x[k] + int'($urandom_range(AW + 5)) - 3;
        py = m_y[k] + int'($urandom_range(AH + 5)) - 3;
      end
    end
    if (px < 0) px = 0;
    if (px > 1023) px = 1023;
    if (py < 0) py = 0;
    if (py > 1023) py = 1023;
    rp = (m_apix && ($urandom % 4000 == 0)) || ($urandom % 3000 == 0);
    rs = m_hit ? ($urandom % 20 == 0) : ($urandom % 400 == 0);
    drive(fr, rp, rs, px, py);
  endtask

  // Monitor: every clk the DUT presents a new output set; compare with the queue head.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("apixel", 32'(apixel), 32'(mon_e.apix));
      chk("hit", 32'(hit), 32'(mon_e.hit));
      chk("score", 32'(score), 32'(mon_e.score));
      chk("active_mask", 32'(active_mask), 32'(mon_e.mask));
    end
  end

  initial begin
    int n;
    int new_seed;
    reset      = 1'b1;
    frame_tick = 1'b0;
    rpixel     = 1'b0;
    restart    = 1'b0;
    x          = '0;
    y          = '0;
    seed       = '0;
    model_reset(0);
    repeat (2) @(negedge clk);
    chk("reset_apixel", 32'(apixel), 32'd0);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_score", 32'(score), 32'd0);
    chk("reset_mask", 32'(active_mask), 32'd0);
    reset = 1'b0;

    // First tick after reset spawns channel 0.
    drive(1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 30000; i++) random_cycle();

    // Asynchronous reset with at least three channels falling.
    n = 0;
    while ($countones(m_mask()) < 3 && n < 5000) begin
      random_cycle();
      n++;
    end
    checks++;
    if ($countones(m_mask()) < 3) begin
      failures++;
      $display("FAIL precondition_three_active actual=%0d required>=3", $countones(m_mask()));
    end
    new_seed   = int'($urandom % 1024);
    #2;
    seed       = 10'(new_seed);
    frame_tick = 1'b1;
    reset      = 1'b1;
    #1;
    chk("async_reset_apixel", 32'(apixel), 32'd0);
    chk("async_reset_hit", 32'(hit), 32'd0);
    chk("async_reset_score", 32'(score), 32'd0);
    chk("async_reset_mask", 32'(active_mask), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("held_reset_score", 32'(score), 32'd0);
    chk("held_reset_mask", 32'(active_mask), 32'd0);
    reset      = 1'b0;
    frame_tick = 1'b0;
    model_reset(new_seed);
    for (int i = 0; i < 8000; i++) random_cycle();

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asteroid_field.md
ASTEROID_FIELD -- requirements
Module: asteroid_field

Interface
REQ-001 Parameter NUM_AST, default 4, number of independent asteroid channels (1..8).
REQ-002 Parameter AST_W, default 30, asteroid width in pixels.
REQ-003 Parameter AST_H, default 20, asteroid height in pixels.
REQ-004 Parameter X_MAX, default 640, active screen width; Y_MAX, default 480, active screen height.
REQ-005 Parameter SPAWN_GAP, default 32, minimum frames between spawns (>=1).
REQ-006 Parameter MAX_SPEED, default 4, fall-speed ceiling in pixels/frame (1..15).
REQ-007 clk  input  1  system clock; reset is asynchronous, active-high; clock is clk.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 frame_tick  input  1  one-clk pulse per video frame, synchronous to clk.
REQ-010 x, y  input  10 each  current pixel coordinate.
REQ-011 seed  input  10  LFSR seed sampled during reset.
REQ-012 rpixel  input  1  rocket pixel, aligned with apixel output timing.
REQ-013 restart  input  1  one-clk pulse, leave HIT and start new game.
REQ-014 apixel  output  1  asteroid covers pixel (x,y) sampled one clk earlier.
REQ-015 hit  output  1  high while in HIT state.
REQ-016 score  output  16  asteroids passed off-screen bottom.
REQ-017 active_mask  output  NUM_AST  bit i high when channel i falling.

Function
REQ-018 Global FSM shall have states PLAY and HIT; PLAY->HIT when rpixel & apixel both high in same clk; HIT->PLAY on restart.
REQ-019 10-bit LFSR shall advance every clk as {l[0]^l[9], l[9:1]}; value 0 shall never occur.
REQ-020 Each channel shall hold active bit, xpos[9:0], ypos[9:0].
REQ-021 Spawn: on frame_tick in PLAY with spawn_cnt==0 and any channel inactive, lowest-index inactive channel shall load xpos = lfsr mod (X_MAX-AST_W+1), ypos=0, active=1, and spawn_cnt shall reload SPAWN_GAP-1.
REQ-022 Otherwise on frame_tick in PLAY spawn_cnt shall decrement, saturating at 0; all channels full shall hold spawn_cnt at 0.
REQ-023 Move: on frame_tick in PLAY every active channel not spawned that tick shall add speed to ypos.
REQ-024 If ypos+speed >= Y_MAX the channel shall instead clear active and score shall increment, saturating at 16'hFFFF; multiple channels exiting same tick shall add their count.
REQ-025 apixel shall register 1 when any active channel satisfies xpos<=x<xpos+AST_W and ypos<=y<ypos+AST_H, 11-bit compare (no wrap).
REQ-026 In HIT frame_tick shall be ignored: no spawn, no move, positions and score frozen, apixel still rendered.
REQ-027 restart in HIT shall clear all channels, score, spawn_cnt in the same clk; restart in PLAY shall be ignored.
REQ-028 Collision and restart in same clk while in HIT shall favour restart (next state PLAY).

Reset
REQ-029 Reset shall force PLAY, all channels inactive with xpos=ypos=0, score=0, spawn_cnt=0, apixel=0, hit=0, active_mask=0.
REQ-030 Reset shall load LFSR with seed, or 10'h001 when seed==0; reset mid-frame shall abort all motion immediately.

Configuration
REQ-031 Macro ASTEROID_FIELD_SPEEDUP_EN defined: speed = min(1 + score[15:3], MAX_SPEED), i.e. +1 every 8 points.
REQ-032 Macro ASTEROID_FIELD_SPEEDUP_EN undefined: speed fixed at 1; no speedup logic synthesised.

Verification
REQ-033 Reset with seed=0 -> LFSR=10'h001, all outputs 0; first frame_tick spawns channel 0, active_mask=4'b0001.
REQ-034 Four frame_ticks spaced SPAWN_GAP=32 frames apart with NUM_AST=4 -> active_mask 0001,0011,0111,1111; fifth spawn attempt blocked, spawn_cnt holds 0.
REQ-035 Single asteroid, speed 1, 480 frame_ticks -> ypos reaches 479 then channel clears on tick 480, score=1.
REQ-036 Drive rpixel=1 at pixel (xpos+5, ypos+5) of active asteroid -> hit=1 next clk, further frame_ticks leave ypos unchanged; restart -> hit=0, score=0, active_mask=0.
REQ-037 With ASTEROID_FIELD_SPEEDUP_EN, score forced past 8 and 24 -> ypos steps of 2 then 4, capped at MAX_SPEED=4 beyond score 24.
REQ-038 Assert reset mid-frame with three channels active -> all outputs zero asynchronously, no score increment.
